fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction address width.
REQ-002 Parameter TIMEOUT, default 15, max cycles awaiting mem_ack before fault.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 fetch  input  1  control-unit signal; request next instruction fetch.
REQ-006 pc_load  input  1  control-unit signal; load pc from pc_load_addr.
REQ-007 pc_load_addr  input  ADDR_W  jump target.
REQ-008 mem_req  output  1  instruction memory request, registered.
REQ-009 mem_addr  output  ADDR_W  instruction memory address, registered.
REQ-010 mem_ack  input  1  memory response strobe; mem_data valid same cycle.
REQ-011 mem_data  input  16  instruction word.
REQ-012 ir  output  16  instruction register.
REQ-013 opcode  output  5  ir[15:11], to control unit opcode input.
REQ-014 ir_valid  output  1  one-cycle pulse: ir updated.
REQ-015 pc  output  ADDR_W  current program counter.
REQ-016 busy  output  1  high while state is not IDLE.
REQ-017 fault  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, LATCH.
REQ-019 IDLE: fetch=1 -> REQ next cycle with mem_req=1, mem_addr=pc.
REQ-020 IDLE: pc_load=1 -> pc<=pc_load_addr next cycle.
REQ-021 IDLE, fetch and pc_load same cycle: pc<=pc_load_addr and mem_addr SHALL equal pc_load_addr (load wins, fetch uses new target).
REQ-022 REQ: mem_req and mem_addr SHALL hold stable until mem_ack sampled high.
REQ-023 REQ with mem_ack=1: ir<=mem_data, pc<=pc+1 (mod 2^ADDR_W, wraps to 0), mem_req<=0, state->LATCH.
REQ-024 LATCH: ir_valid=1 for exactly this one cycle; state->IDLE next cycle.
REQ-025 Latency: fetch at cycle N, ack at first REQ cycle (N+1) -> ir_valid at N+2.
REQ-026 fetch and pc_load SHALL be ignored outside IDLE (no queuing).
REQ-027 mem_ack outside REQ SHALL be ignored.
REQ-028 Timeout counter clears on entry to REQ, increments each REQ cycle without ack; reaching TIMEOUT -> mem_req<=0, fault<=1, state->IDLE, ir and pc unchanged, no ir_valid.
REQ-029 mem_ack on the cycle the counter reaches TIMEOUT SHALL be accepted (ack wins, no fault).
REQ-030 fault SHALL stay 1 until rst; fetches still proceed while fault=1.
REQ-031 opcode SHALL be combinational ir[15:11]; all other outputs registered.

Reset
REQ-032 On rst: state=IDLE, pc=0, ir=0, mem_req=0, mem_addr=0, ir_valid=0, fault=0, counter=0.
REQ-033 rst mid-REQ SHALL drop mem_req next cycle and discard any same-cycle mem_ack.
REQ-034 rst SHALL override fetch, pc_load and mem_ack in the same cycle.

Structure
REQ-035 constants.v SHALL hold FSM state encodings, opcode field bounds (15:11), instruction width 16, default ADDR_W and TIMEOUT.
REQ-036 One sub-module is natural: pc_counter (load, increment with wrap, reset to 0).

Verification
REQ-037 rst, fetch pulse, memory acks first REQ cycle with 16'h3A5C -> ir_valid two cycles later, ir=16'h3A5C, opcode=5'b00111, pc=1.
REQ-038 pc_load 8'hFF then fetch, ack with 16'h4000 -> mem_addr=8'hFF, opcode=5'b01000, pc wraps to 0.
REQ-039 fetch and pc_load=8'h20 same cycle -> mem_addr=8'h20, after ack pc=8'h21.
REQ-040 fetch, no ack for 15 cycles -> mem_req falls, fault=1, busy=0, ir and pc unchanged; next fetch with ack succeeds, fault stays 1.
REQ-041 fetch asserted during REQ and ack asserted in IDLE -> no extra request, ir unchanged.
REQ-042 rst during REQ with simultaneous ack -> mem_req=0, ir=0, pc=0, no ir_valid.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: state encodings, instruction
// word layout and default parameter values.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_LATCH = 2'd2
    } fetch_state_e;

    localparam int INSTR_W     = 16;
    localparam int OPC_HI      = 15;
    localparam int OPC_LO      = 11;
    localparam int OPC_W       = OPC_HI - OPC_LO + 1;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: synchronous reset to 0, load has priority over increment,
// increment wraps modulo 2^ADDR_W.
module fetch_unit_pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (load_i) begin
            pc_q <= load_addr_i;
        end else if (inc_i) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request per fetch, latches the
// returned word into ir, advances pc, and flags a sticky fault on ack timeout.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for fetch / pc_load from the control unit
//   ST_REQ   | mem_req held high, waiting for mem_ack or timeout
//   ST_LATCH | ir just updated, ir_valid high for this cycle only
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [OPC_W-1:0]   opcode,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fault
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e       state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pc_load_en;
    logic               pc_inc_en;

    fetch_unit_pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pc_load_en),
        .load_addr_i (pc_load_addr),
        .inc_i       (pc_inc_en),
        .pc_o        (pc)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        pc_load_en = 1'b0;
        pc_inc_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_load_en = pc_load;
                if (fetch) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    // A same-cycle load redirects this fetch to the new target.
                    mem_addr_d = pc_load ? pc_load_addr : pc;
                    cnt_d      = '0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ir_d      = mem_data;
                    pc_inc_en = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_LATCH;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= (state_d == ST_LATCH);
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign opcode   = ir_q[OPC_HI:OPC_LO];
    assign ir_valid = ir_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, basic fetch, pc wrap, load+fetch,
// ack at the timeout limit, timeout fault, ignored inputs and reset mid-request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch;
    logic        pc_load;
    logic [7:0]  pc_load_addr;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        ir_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        fault;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch        (fetch),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .ir           (ir),
        .opcode       (opcode),
        .ir_valid     (ir_valid),
        .pc           (pc),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; fetch = 1'b0; pc_load = 1'b0; pc_load_addr = '0;
        mem_ack = 1'b0; mem_data = '0;
        step(2);
        rst = 1'b0;
        checks++; if ({mem_req, ir_valid, busy, fault} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b want=0000", {mem_req, ir_valid, busy, fault}); errors++; end
        checks++; if (pc !== 8'h00) begin
            $display("FAIL reset_pc got=%h want=00", pc); errors++; end
        checks++; if (ir !== 16'h0000) begin
            $display("FAIL reset_ir got=%h want=0000", ir); errors++; end
        checks++; if (mem_addr !== 8'h00) begin
            $display("FAIL reset_mem_addr got=%h want=00", mem_addr); errors++; end
    endtask

    task automatic test_basic_fetch;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        checks++; if ({mem_req, busy, ir_valid} !== 3'b110 || mem_addr !== 8'h00) begin
            $display("FAIL basic_req got req/busy/valid=%b addr=%h want=110 addr=00", {mem_req, busy, ir_valid}, mem_addr); errors++; end
        mem_ack = 1'b1; mem_data = 16'h3A5C;
        step();
        mem_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || ir !== 16'h3A5C || opcode !== 5'b00111) begin
            $display("FAIL basic_latch got valid=%b ir=%h opc=%b want 1 3a5c 00111", ir_valid, ir, opcode); errors++; end
        checks++; if (pc !== 8'h01 || mem_req !== 1'b0) begin
            $display("FAIL basic_pc got pc=%h req=%b want 01 0", pc, mem_req); errors++; end
        step();
        checks++; if (ir_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_idle got valid=%b busy=%b want 0 0", ir_valid, busy); errors++; end
    endtask

    task automatic test_pc_wrap;
        pc_load = 1'b1; pc_load_addr = 8'hFF;
        step();
        pc_load = 1'b0;
        checks++; if (pc !== 8'hFF || busy !== 1'b0) begin
            $display("FAIL wrap_load got pc=%h busy=%b want ff 0", pc, busy); errors++; end
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        checks++; if (mem_addr !== 8'hFF || mem_req !== 1'b1) begin
            $display("FAIL wrap_req got addr=%h req=%b want ff 1", mem_addr, mem_req); errors++; end
        mem_ack = 1'b1; mem_data = 16'h4000;
        step();
        mem_ack = 1'b0;
        checks++; if (opcode !== 5'b01000 || pc !== 8'h00 || ir_valid !== 1'b1) begin
            $display("FAIL wrap_latch got opc=%b pc=%h valid=%b want 01000 00 1", opcode, pc, ir_valid); errors++; end
        step();
    endtask

    task automatic test_load_and_fetch;
        fetch = 1'b1; pc_load = 1'b1; pc_load_addr = 8'h20;
        step();
        fetch = 1'b0; pc_load = 1'b0;
        checks++; if (mem_addr !== 8'h20 || pc !== 8'h20 || mem_req !== 1'b1) begin
            $display("FAIL loadfetch_req got addr=%h pc=%h req=%b want 20 20 1", mem_addr, pc, mem_req); errors++; end
        mem_ack = 1'b1; mem_data = 16'h1234;
        step();
        mem_ack = 1'b0;
        checks++; if (pc !== 8'h21 || ir !== 16'h1234) begin
            $display("FAIL loadfetch_ack got pc=%h ir=%h want 21 1234", pc, ir); errors++; end
        step();
    endtask

    task automatic test_ack_at_limit;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        step(14);
        checks++; if (mem_req !== 1'b1 || fault !== 1'b0 || mem_addr !== 8'h21) begin
            $display("FAIL limit_hold got req=%b fault=%b addr=%h want 1 0 21", mem_req, fault, mem_addr); errors++; end
        mem_ack = 1'b1; mem_data = 16'h5555;
        step();
        mem_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || fault !== 1'b0 || ir !== 16'h5555 || pc !== 8'h22) begin
            $display("FAIL limit_ack got valid=%b fault=%b ir=%h pc=%h want 1 0 5555 22", ir_valid, fault, ir, pc); errors++; end
        step();
    endtask

    task automatic test_timeout;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        step(14);
        checks++; if (mem_req !== 1'b1 || fault !== 1'b0) begin
            $display("FAIL timeout_pre got req=%b fault=%b want 1 0", mem_req, fault); errors++; end
        step();
        checks++; if ({mem_req, fault, busy, ir_valid} !== 4'b0100) begin
            $display("FAIL timeout_flags got req/fault/busy/valid=%b want 0100", {mem_req, fault, busy, ir_valid}); errors++; end
        checks++; if (ir !== 16'h5555 || pc !== 8'h22) begin
            $display("FAIL timeout_keep got ir=%h pc=%h want 5555 22", ir, pc); errors++; end
        step();
        checks++; if (ir_valid !== 1'b0 || fault !== 1'b1) begin
            $display("FAIL timeout_after got valid=%b fault=%b want 0 1", ir_valid, fault); errors++; end
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        mem_ack = 1'b1; mem_data = 16'hF800;
        step();
        mem_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || ir !== 16'hF800 || opcode !== 5'b11111 || pc !== 8'h23 || fault !== 1'b1) begin
            $display("FAIL timeout_refetch got valid=%b ir=%h opc=%b pc=%h fault=%b want 1 f800 11111 23 1", ir_valid, ir, opcode, pc, fault); errors++; end
        step();
    endtask

    task automatic test_ignored_inputs;
        fetch = 1'b1;
        step();
        pc_load = 1'b1; pc_load_addr = 8'h80;
        step(2);
        checks++; if (mem_addr !== 8'h23 || pc !== 8'h23 || mem_req !== 1'b1) begin
            $display("FAIL ignore_req got addr=%h pc=%h req=%b want 23 23 1", mem_addr, pc, mem_req); errors++; end
        fetch = 1'b0; pc_load = 1'b0;
        mem_ack = 1'b1; mem_data = 16'h1111;
        step();
        checks++; if (ir_valid !== 1'b1 || pc !== 8'h24) begin
            $display("FAIL ignore_ack got valid=%b pc=%h want 1 24", ir_valid, pc); errors++; end
        fetch = 1'b1; pc_load = 1'b1; mem_data = 16'hBEEF;
        step();
        fetch = 1'b0; pc_load = 1'b0;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || ir !== 16'h1111 || pc !== 8'h24) begin
            $display("FAIL ignore_latch got req=%b busy=%b ir=%h pc=%h want 0 0 1111 24", mem_req, busy, ir, pc); errors++; end
        step(2);
        mem_ack = 1'b0;
        checks++; if (ir !== 16'h1111 || ir_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL ignore_idle_ack got ir=%h valid=%b busy=%b req=%b want 1111 0 0 0", ir, ir_valid, busy, mem_req); errors++; end
    endtask

    task automatic test_reset_mid_req;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        checks++; if (mem_req !== 1'b1) begin
            $display("FAIL rstreq_pre got req=%b want 1", mem_req); errors++; end
        rst = 1'b1; mem_ack = 1'b1; mem_data = 16'h7777;
        step();
        checks++; if ({mem_req, ir_valid, busy, fault} !== 4'b0000 || ir !== 16'h0000 || pc !== 8'h00) begin
            $display("FAIL rstreq_state got flags=%b ir=%h pc=%h want 0000 0000 00", {mem_req, ir_valid, busy, fault}, ir, pc); errors++; end
        rst = 1'b0; mem_ack = 1'b0;
        step();
        checks++; if (ir_valid !== 1'b0 || ir !== 16'h0000 || busy !== 1'b0) begin
            $display("FAIL rstreq_after got valid=%b ir=%h busy=%b want 0 0000 0", ir_valid, ir, busy); errors++; end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_pc_wrap();
        test_load_and_fetch();
        test_ack_at_limit();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
